sevenseg_scan_ctl: RTL and testbench

Time-multiplexed scan controller for the board's common-anode seven-segment bank. It holds a double-buffered array of 7-bit extended digit codes and walks one digit per refresh slot. For each slot it drives the active-low anode select and the current code to the team's extended seven-segment decoder.
Host logic writes codes into a staging buffer and commits them. The commit takes effect only at a frame boundary, so the display never tears.

---
 rtl/sevenseg_pkg.sv | 18 +
 rtl/sevenseg_scan_timer.sv | 36 +++
 rtl/sevenseg_scan_ctl.sv | 103 ++++++++++
 tb/tb_sevenseg_scan_ctl.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sevenseg_pkg.sv
// Shared types and code constants for the seven-segment scan controller.
package sevenseg_pkg;

  typedef struct packed {
    logic       blank;
    logic       dp;
    logic       dash;
    logic [3:0] val;
  } digit_code_t;

  localparam logic [6:0] CODE_BLANK = 7'h40;
  localparam logic [6:0] CODE_DASH  = 7'h10;
  localparam logic [6:0] CODE_ZERO  = 7'h00;

  // Buffers are sized for the largest bank so a 3-bit index always fits.
  localparam int MAX_DIGITS = 8;

endpackage

// File: rtl/sevenseg_scan_timer.sv
// Slot counter and digit index for the scan controller.
// o_boundary marks the cycle in which idx wraps from NDIGITS-1 back to 0.
module scan_timer #(
  parameter int NDIGITS     = 8,
  parameter int REFRESH_DIV = 100000,
  parameter int CW          = 17
) (
  input  logic          clk,
  input  logic          rst,
  output logic [CW-1:0] o_cnt,
  output logic [2:0]    o_idx,
  output logic          o_boundary
);

  logic [CW-1:0] r_cnt;
  logic [2:0]    r_idx;
  logic          w_tc;

  assign w_tc       = (r_cnt == CW'(REFRESH_DIV - 1));
  assign o_boundary = w_tc && (r_idx == 3'(NDIGITS - 1));
  assign o_cnt      = r_cnt;
  assign o_idx      = r_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else if (w_tc) begin
      r_cnt <= '0;
      r_idx <= o_boundary ? 3'd0 : r_idx + 3'd1;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/sevenseg_scan_ctl.sv
// Seven-segment scan controller: double-buffered digit codes, frame-aligned
// commit, leading-zero suppression and registered anode/code outputs.
module sevenseg_scan_ctl
  import sevenseg_pkg::*;
#(
  parameter int NDIGITS      = 8,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [2:0]         wr_addr,
  input  logic [6:0]         wr_code,
  input  logic               commit,
  input  logic               blank_lz,
  output logic [6:0]         d,
  output logic [NDIGITS-1:0] an_n,
  output logic               frame_start,
  output logic               pending
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  logic [CW-1:0] w_cnt;
  logic [2:0]    w_idx;
  logic          w_boundary;

  digit_code_t r_stage  [MAX_DIGITS];
  digit_code_t r_active [MAX_DIGITS];
  digit_code_t w_stage_nxt [MAX_DIGITS];
  digit_code_t w_disp   [MAX_DIGITS];

  logic               r_pending;
  logic               r_wrap;
  logic               r_fs;
  logic [NDIGITS-1:0] r_an_n;
  logic [6:0]         r_d;

  scan_timer #(
    .NDIGITS     (NDIGITS),
    .REFRESH_DIV (REFRESH_DIV),
    .CW          (CW)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .o_cnt      (w_cnt),
    .o_idx      (w_idx),
    .o_boundary (w_boundary)
  );

  // Staging with this cycle's write merged in, so a swap captures it.
  always_comb begin
    w_stage_nxt = r_stage;
    if (wr_en && (int'(wr_addr) < NDIGITS))
      w_stage_nxt[wr_addr] = wr_code;
  end

  always_comb begin : lz_suppress
    logic v_lead;
    w_disp = r_active;
    v_lead = 1'b1;
    for (int i = NDIGITS - 1; i >= 1; i--) begin
      if (blank_lz && v_lead && (r_active[i] == CODE_ZERO))
        w_disp[i] = CODE_BLANK;
      v_lead = v_lead && ((r_active[i] == CODE_ZERO) || r_active[i].blank);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MAX_DIGITS; i++) begin
        r_stage[i]  <= CODE_BLANK;
        r_active[i] <= CODE_BLANK;
      end
      r_pending <= 1'b0;
      r_wrap    <= 1'b0;
      r_fs      <= 1'b0;
      r_an_n    <= '1;
      r_d       <= CODE_BLANK;
    end else begin
      r_stage <= w_stage_nxt;
      if (w_boundary && r_pending) begin
        r_active  <= w_stage_nxt;
        r_pending <= 1'b0;
      end else if (commit) begin
        r_pending <= 1'b1;
      end
      // Delay the wrap so the pulse lines up with the outputs, and so the
      // partial first slot after reset never raises frame_start.
      r_wrap <= w_boundary;
      r_fs   <= r_wrap;
      r_an_n <= (int'(w_cnt) < BLANK_CYCLES) ? '1 : ~(NDIGITS'(1) << w_idx);
      r_d    <= w_disp[w_idx];
    end
  end

  assign d           = r_d;
  assign an_n        = r_an_n;
  assign frame_start = r_fs;
  assign pending     = r_pending;

endmodule

// File: tb/tb_sevenseg_scan_ctl.sv
// Scoreboard bench for sevenseg_scan_ctl with NDIGITS=4, REFRESH_DIV=4, BLANK_CYCLES=1.
module tb_sevenseg_scan_ctl;
  localparam int N  = 4;
  localparam int RD = 4;
  localparam int BL = 1;

  logic       clk = 1'b0, rst = 1'b1, wr_en = 1'b0, commit = 1'b0, blank_lz = 1'b0;
  logic [2:0] wr_addr = 3'd0;
  logic [6:0] wr_code = 7'd0;
  logic [6:0] d;
  logic [3:0] an_n;
  logic       frame_start, pending;

  always #5 clk = ~clk;

  sevenseg_scan_ctl #(.NDIGITS(N), .REFRESH_DIV(RD), .BLANK_CYCLES(BL)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_code(wr_code),
    .commit(commit), .blank_lz(blank_lz), .d(d), .an_n(an_n),
    .frame_start(frame_start), .pending(pending)
  );

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] d;
    logic       fs;
    logic       pend;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   n_tests = 0, n_fail = 0;

  int         m_cnt, m_idx;
  logic [6:0] m_stage [N];
  logic [6:0] m_active[N];
  bit         m_pend, m_seen;

  function automatic logic [6:0] m_disp(int i);
    if (!blank_lz || i == 0 || m_active[i] != 7'h00) return m_active[i];
    for (int j = N - 1; j > i; j--)
      if (m_active[j] != 7'h00 && !m_active[j][6]) return m_active[i];
    return 7'h40;
  endfunction

  // Reference model: predicts the registered outputs produced by each edge.
  always @(posedge clk) begin : model
    exp_t x;
    bit   bnd;
    if (rst) begin
      m_cnt = 0; m_idx = 0; m_pend = 0; m_seen = 0;
      for (int i = 0; i < N; i++) begin m_stage[i] = 7'h40; m_active[i] = 7'h40; end
      x = {4'hF, 7'h40, 1'b0, 1'b0};
    end else begin
      x.an = (m_cnt < BL) ? 4'hF : ~(4'b0001 << m_idx);
      x.d  = m_disp(m_idx);
      x.fs = m_seen && m_cnt == 0 && m_idx == 0;
      bnd  = (m_cnt == RD - 1) && (m_idx == N - 1);
      if (wr_en && int'(wr_addr) < N) m_stage[int'(wr_addr)] = wr_code;
      if (bnd && m_pend) begin
        for (int i = 0; i < N; i++) m_active[i] = m_stage[i];
        m_pend = 0;
      end else if (commit) m_pend = 1;
      if (bnd) m_seen = 1;
      if (m_cnt == RD - 1) begin m_cnt = 0; m_idx = (m_idx + 1) % N; end
      else m_cnt++;
      x.pend = m_pend;
    end
    q.push_back(x);
  end

  task automatic tick();
    @(negedge clk);
    if (q.size() == 0) begin
      n_tests++; n_fail++;
      $display("FAIL scoreboard_empty: got no entry, required one per cycle");
      e = '0;
    end else e = q.pop_front();
  endtask

  task automatic wait_fs(output bit found);
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      found = (frame_start === 1'b1);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_tests++;
      if ({an_n, d, frame_start, pending} !== {4'hF, 7'h40, 2'b00}) begin
        n_fail++;
        $display("FAIL reset_vals: got %h required %h", {an_n, d, frame_start, pending}, {4'hF, 7'h40, 2'b00});
      end
    end
    rst = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      logic [3:0] want_an;
      int c, ix;
      tick();
      n_tests++;
      if ({an_n, d, frame_start, pending} !== e) begin
        n_fail++;
        $display("FAIL idle_model k=%0d: got %h required %h", k, {an_n, d, frame_start, pending}, e);
      end
      c  = (k - 1) % 4;
      ix = ((k - 1) / 4) % 4;
      want_an = (c == 0) ? 4'hF : ~(4'b0001 << ix);
      n_tests++;
      if ({an_n, d, frame_start, pending} !== {want_an, 7'h40, (k == 17 || k == 33), 1'b0}) begin
        n_fail++;
        $display("FAIL idle_scan k=%0d: got %h required %h", k, {an_n, d, frame_start, pending},
                 {want_an, 7'h40, (k == 17 || k == 33), 1'b0});
      end
    end
  endtask

  task automatic test_commit();
    bit f;
    wait_fs(f);
    for (int a = 0; a < 4; a++) begin
      wr_en = 1'b1; wr_addr = 3'(a); wr_code = 7'(a + 1);
      tick();
      n_tests++;
      if ({an_n, d, frame_start, pending} !== e) begin
        n_fail++;
        $display("FAIL write_model a=%0d: got %h required %h", a, {an_n, d, frame_start, pending}, e);
      end
    end
    wr_en = 1'b0; commit = 1'b1;
    tick();
    commit = 1'b0;
    n_tests++;
    if (pending !== 1'b1 || d !== 7'h40) begin
      n_fail++;
      $display("FAIL commit_pending: got pend=%b d=%h required pend=1 d=40", pending, d);
    end
    wait_fs(f);
    n_tests++;
    if (!f) begin n_fail++; $display("FAIL commit_fs: got no frame_start, required within 40 cycles"); end
    for (int k = 0; k < 16; k++) begin
      if (k > 0) tick();
      n_tests++;
      if (d !== 7'(k / 4 + 1) || pending !== 1'b0 || {an_n, d, frame_start, pending} !== e) begin
        n_fail++;
        $display("FAIL commit_show k=%0d: got %h required %h d=%h", k, {an_n, d, frame_start, pending}, e, 7'(k / 4 + 1));
      end
    end
  endtask

  task automatic test_rewrite();
    bit f;
    wait_fs(f);
    tick(); tick();
    wr_en = 1'b1; wr_addr = 3'd2; wr_code = 7'h25; commit = 1'b1;
    tick();
    wr_en = 1'b0; commit = 1'b0;
    tick(); tick(); tick();
    wr_en = 1'b1; wr_code = 7'h0A; commit = 1'b1;
    tick();
    wr_en = 1'b0; commit = 1'b0;
    n_tests++;
    if (pending !== 1'b1) begin n_fail++; $display("FAIL rewrite_pend: got %b required 1", pending); end
    wait_fs(f);
    for (int k = 0; k < 16; k++) begin
      if (k > 0) tick();
      n_tests++;
      if ((k / 4 == 2 && d !== 7'h0A) || {an_n, d, frame_start, pending} !== e) begin
        n_fail++;
        $display("FAIL rewrite_show k=%0d: got %h required %h", k, {an_n, d, frame_start, pending}, e);
      end
    end
    wr_en = 1'b1; wr_code = 7'h0B;
    tick();
    wr_en = 1'b0;
    wait_fs(f);
    for (int k = 0; k < 16; k++) begin
      if (k > 0) tick();
      n_tests++;
      if ((k / 4 == 2 && d !== 7'h0A) || pending !== 1'b0) begin
        n_fail++;
        $display("FAIL single_swap k=%0d: got d=%h pend=%b required d=0a pend=0", k, d, pending);
      end
    end
  endtask

  task automatic test_lz();
    bit f;
    logic [6:0] want[4];
    wait_fs(f);
    blank_lz = 1'b1;
    for (int a = 0; a < 4; a++) begin
      wr_en = 1'b1; wr_addr = 3'(a); wr_code = 7'h00; commit = (a == 3);
      tick();
    end
    wr_en = 1'b0; commit = 1'b0;
    wait_fs(f);
    want = '{7'h00, 7'h40, 7'h40, 7'h40};
    for (int k = 0; k < 16; k++) begin
      if (k > 0) tick();
      n_tests++;
      if (d !== want[k / 4] || {an_n, d, frame_start, pending} !== e) begin
        n_fail++;
        $display("FAIL lz_all_zero k=%0d: got d=%h required d=%h", k, d, want[k / 4]);
      end
    end
    wr_en = 1'b1; wr_addr = 3'd2; wr_code = 7'h07; commit = 1'b1;
    tick();
    wr_en = 1'b0; commit = 1'b0;
    wait_fs(f);
    want = '{7'h00, 7'h00, 7'h07, 7'h40};
    for (int k = 0; k < 16; k++) begin
      if (k > 0) tick();
      n_tests++;
      if (d !== want[k / 4] || {an_n, d, frame_start, pending} !== e) begin
        n_fail++;
        $display("FAIL lz_inner k=%0d: got d=%h required d=%h", k, d, want[k / 4]);
      end
    end
    blank_lz = 1'b0;
    wait_fs(f);
    want = '{7'h00, 7'h00, 7'h07, 7'h00};
    for (int k = 0; k < 16; k++) begin
      if (k > 0) tick();
      n_tests++;
      if (d !== want[k / 4] || {an_n, d, frame_start, pending} !== e) begin
        n_fail++;
        $display("FAIL lz_off k=%0d: got d=%h required d=%h", k, d, want[k / 4]);
      end
    end
  endtask

  task automatic test_bad_addr();
    bit f;
    logic [6:0] want[4];
    wait_fs(f);
    wr_en = 1'b1; wr_addr = 3'd5; wr_code = 7'h7F; commit = 1'b1;
    tick();
    wr_en = 1'b0; commit = 1'b0;
    wait_fs(f);
    want = '{7'h00, 7'h00, 7'h07, 7'h00};
    for (int k = 0; k < 16; k++) begin
      if (k > 0) tick();
      n_tests++;
      if (d !== want[k / 4] || pending !== 1'b0 || {an_n, d, frame_start, pending} !== e) begin
        n_fail++;
        $display("FAIL bad_addr k=%0d: got d=%h pend=%b required d=%h pend=0", k, d, pending, want[k / 4]);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit f;
    wait_fs(f);
    for (int k = 0; k < 5; k++) tick();
    wr_en = 1'b1; wr_addr = 3'd0; wr_code = 7'h03; commit = 1'b1;
    tick();
    wr_en = 1'b0; commit = 1'b0;
    tick();
    n_tests++;
    if (pending !== 1'b1) begin n_fail++; $display("FAIL mid_pend: got %b required 1", pending); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_tests++;
    if ({an_n, d, pending} !== {4'hF, 7'h40, 1'b0} || {an_n, d, frame_start, pending} !== e) begin
      n_fail++;
      $display("FAIL mid_reset: got %h required %h", {an_n, d, frame_start, pending}, {4'hF, 7'h40, 2'b00});
    end
    for (int k = 1; k <= 20; k++) begin
      tick();
      n_tests++;
      if (d !== 7'h40 || frame_start !== (k == 17) || pending !== 1'b0 ||
          {an_n, d, frame_start, pending} !== e) begin
        n_fail++;
        $display("FAIL post_reset k=%0d: got %h required %h", k, {an_n, d, frame_start, pending}, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_commit();
    test_rewrite();
    test_lz();
    test_bad_addr();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
